plru_tree_param: RTL and testbench

PLRU_TREE_PARAM -- requirements
Module: plru_tree_param

---
 rtl/plru_tree_param.sv | 158 +++++++++++++++
 tb/tb_plru_tree_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/plru_tree_param.sv
// ---------------------------------------------------------------------------
// plru_tree_param
//   Tree pseudo-LRU replacement state for a set-associative cache.
//   Holds one (NUM_WAYS-1)-bit heap-ordered tree per set and answers one
//   victim query per cycle with a fixed one-cycle latency.
//
//   Tree encoding: root is node 0 and node i has children 2i+1 (left) and
//   2i+2 (right). Touching a way stores the way's own path bit in each node
//   on its path. The victim walk goes the other way at each node, so a 1
//   steers left and a 0 steers right. An all-zero tree points at the
//   highest way.
//
//   Optional feature (macro PLRU_INVALID_FIRST_EN):
//     When defined, a query whose valid_mask has any 0 bit returns the
//     lowest-numbered invalid way instead of the tree victim. State update
//     and latency are the same in both builds.
//
// Ports
//   clk         : clock, all state changes on its rising edge
//   rst         : asynchronous active-low reset
//   upd_valid   : record an access to (upd_index, upd_way)
//   upd_index   : set of the access
//   upd_way     : way accessed (every W-bit value is a legal way)
//   clr_valid   : return set clr_index to its reset state (beats an update)
//   clr_index   : set to clear
//   vic_req     : victim query for set vic_index
//   vic_index   : set queried
//   valid_mask  : per-way line-valid bits of the queried set
//   vic_valid   : one-cycle response strobe, one cycle after vic_req
//   vic_way     : registered victim way, held until the next response
// ---------------------------------------------------------------------------
module plru_tree_param #(
  parameter int NUM_WAYS = 8,
  parameter int S_INDEX  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        upd_valid,
  input  logic [S_INDEX-1:0]          upd_index,
  input  logic [$clog2(NUM_WAYS)-1:0] upd_way,
  input  logic                        clr_valid,
  input  logic [S_INDEX-1:0]          clr_index,
  input  logic                        vic_req,
  input  logic [S_INDEX-1:0]          vic_index,
  input  logic [NUM_WAYS-1:0]         valid_mask,
  output logic                        vic_valid,
  output logic [$clog2(NUM_WAYS)-1:0] vic_way
);

  localparam int W     = $clog2(NUM_WAYS);
  localparam int NODES = NUM_WAYS - 1;
  localparam int SETS  = 1 << S_INDEX;

  // Node indices stay below NUM_WAYS-1, so W bits address every node.
  // Child index is 2*idx + 1 + dir, formed as {idx,1} + dir.
  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] tree,
                                                  input logic [W-1:0]     way);
    logic [NODES-1:0] t;
    logic [W-1:0]     idx;
    logic [W-1:0]     sh;
    logic             dir;
    t   = tree;
    idx = '0;
    sh  = way;
    for (int k = 0; k < W; k++) begin
      dir    = sh[W-1];
      t[idx] = dir;
      idx    = W'({idx, 1'b1} + {{W{1'b0}}, dir});
      sh     = sh << 1;
    end
    return t;
  endfunction

  function automatic logic [W-1:0] plru_victim(input logic [NODES-1:0] tree);
    logic [W-1:0] idx;
    logic [W-1:0] way;
    logic         dir;
    idx = '0;
    way = '0;
    for (int k = 0; k < W; k++) begin
      dir = ~tree[idx];               // stored 1 -> left (0), stored 0 -> right (1)
      way = W'({way, dir});
      idx = W'({idx, 1'b1} + {{W{1'b0}}, dir});
    end
    return way;
  endfunction

  // Next-state of every set; the query reads this so same-cycle update and
  // clear are already folded into the answer.
  logic [NODES-1:0] tree_nxt [SETS];

  for (genvar s = 0; s < SETS; s++) begin : g_set
    logic [NODES-1:0] tree_r;
    logic             upd_hit;
    logic             clr_hit;

    assign upd_hit     = upd_valid && (upd_index == S_INDEX'(s));
    assign clr_hit     = clr_valid && (clr_index == S_INDEX'(s));
    assign tree_nxt[s] = clr_hit ? '0
                       : upd_hit ? plru_touch(tree_r, upd_way)
                       : tree_r;

    // NOTE: the trees are flops, not a RAM, so every set must be reset to a
    // known all-zero tree; an unreset set would give an arbitrary victim.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) tree_r <= '0;
      else      tree_r <= tree_nxt[s];
    end
  end

  logic [W-1:0] tree_way;
  logic [W-1:0] sel_way;

  assign tree_way = plru_victim(tree_nxt[vic_index]);

`ifdef PLRU_INVALID_FIRST_EN
  logic [W-1:0] inv_way;

  // Lowest-numbered cleared bit of valid_mask.
  always_comb begin
    logic [NUM_WAYS-1:0] m;
    logic [W-1:0]        cnt;
    logic                found;
    inv_way = '0;
    m       = valid_mask;
    cnt     = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_WAYS; k++) begin
      if (!found && !m[0]) begin
        found   = 1'b1;
        inv_way = cnt;
      end
      m   = m >> 1;
      cnt = cnt + 1'b1;
    end
  end

  assign sel_way = (&valid_mask) ? tree_way : inv_way;
`else
  // valid_mask has no effect in this build; only the tree decides.
  logic unused_mask;
  assign unused_mask = ^valid_mask;
  assign sel_way     = tree_way;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vic_valid <= 1'b0;
      vic_way   <= '0;
    end else begin
      vic_valid <= vic_req;
      if (vic_req) vic_way <= sel_way;
    end
  end

endmodule

// File: tb/tb_plru_tree_param.sv
// ---------------------------------------------------------------------------
// tb_plru_tree_param
//   Directed bench for plru_tree_param with NUM_WAYS=8, S_INDEX=3.
//   Inputs change 1 time unit after a rising edge; outputs are sampled at
//   the same point, i.e. after the edge that produced them.
// ---------------------------------------------------------------------------
module tb_plru_tree_param;

  logic       clk;
  logic       rst;
  logic       upd_valid;
  logic [2:0] upd_index;
  logic [2:0] upd_way;
  logic       clr_valid;
  logic [2:0] clr_index;
  logic       vic_req;
  logic [2:0] vic_index;
  logic [7:0] valid_mask;
  logic       vic_valid;
  logic [2:0] vic_way;

  int n_checks = 0;
  int n_errors = 0;

  plru_tree_param #(.NUM_WAYS(8), .S_INDEX(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .upd_valid  (upd_valid),
    .upd_index  (upd_index),
    .upd_way    (upd_way),
    .clr_valid  (clr_valid),
    .clr_index  (clr_index),
    .vic_req    (vic_req),
    .vic_index  (vic_index),
    .valid_mask (valid_mask),
    .vic_valid  (vic_valid),
    .vic_way    (vic_way)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic update(input logic [2:0] idx, input logic [2:0] way);
    upd_valid = 1'b1;
    upd_index = idx;
    upd_way   = way;
    step();
    upd_valid = 1'b0;
  endtask

  task automatic query(input logic [2:0] idx, input logic [7:0] mask,
                       input logic [2:0] exp, input string tag);
    vic_req    = 1'b1;
    vic_index  = idx;
    valid_mask = mask;
    step();
    vic_req    = 1'b0;
    valid_mask = 8'hFF;
    check({tag, "_valid"}, vic_valid, 1);
    check(tag, vic_way, exp);
  endtask

  task automatic clear(input logic [2:0] idx);
    clr_valid = 1'b1;
    clr_index = idx;
    step();
    clr_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    upd_valid  = 1'b0;
    upd_index  = '0;
    upd_way    = '0;
    clr_valid  = 1'b0;
    clr_index  = '0;
    vic_req    = 1'b0;
    vic_index  = '0;
    valid_mask = 8'hFF;

    #12;
    check("rst_valid", vic_valid, 0);
    check("rst_way",   vic_way,   0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Reset tree points at the highest way; strobe lasts one cycle, way holds.
    query(3'd0, 8'hFF, 3'd7, "reset_victim");
    step();
    check("strobe_drop", vic_valid, 0);
    check("way_hold",    vic_way,   7);

    // Single touches.
    update(3'd1, 3'd7);
    query(3'd1, 8'hFF, 3'd3, "touch_w7");
    clear(3'd1);
    query(3'd1, 8'hFF, 3'd7, "cleared_set");
    update(3'd1, 3'd5);
    query(3'd1, 8'hFF, 3'd3, "touch_w5");

    // Sequential sweep makes way 0 the victim; neighbour set untouched.
    for (int w = 0; w < 8; w++) update(3'd4, 3'(w));
    query(3'd4, 8'hFF, 3'd0, "sweep");
    query(3'd5, 8'hFF, 3'd7, "neighbour");
    update(3'd4, 3'd0);
    query(3'd4, 8'hFF, 3'd4, "sweep_then_w0");

    // Same-cycle bypass, then clear beats update.
    upd_valid = 1'b1; upd_index = 3'd2; upd_way = 3'd7;
    vic_req   = 1'b1; vic_index = 3'd2;
    step();
    upd_valid = 1'b0; vic_req = 1'b0;
    check("bypass_valid", vic_valid, 1);
    check("bypass_way",   vic_way,   3);
    upd_valid = 1'b1; upd_index = 3'd2; upd_way = 3'd7;
    clr_valid = 1'b1; clr_index = 3'd2;
    vic_req   = 1'b1; vic_index = 3'd2;
    step();
    upd_valid = 1'b0; clr_valid = 1'b0; vic_req = 1'b0;
    check("clr_bypass_way", vic_way, 7);
    query(3'd2, 8'hFF, 3'd7, "clr_wins");

    // Different sets in one cycle are independent.
    upd_valid = 1'b1; upd_index = 3'd6; upd_way = 3'd7;
    clr_valid = 1'b1; clr_index = 3'd4;
    vic_req   = 1'b1; vic_index = 3'd7;
    step();
    upd_valid = 1'b0; clr_valid = 1'b0; vic_req = 1'b0;
    check("indep_query", vic_way, 7);
    query(3'd6, 8'hFF, 3'd3, "indep_update");
    query(3'd4, 8'hFF, 3'd7, "indep_clear");

    // Invalid-way preference (build dependent).
`ifdef PLRU_INVALID_FIRST_EN
    query(3'd0, 8'b1111_1011, 3'd2, "mask_one_hole");
    query(3'd0, 8'b0000_0000, 3'd0, "mask_empty");
`else
    query(3'd0, 8'b1111_1011, 3'd7, "mask_ignored");
    query(3'd0, 8'b0000_0000, 3'd7, "mask_empty_ignored");
`endif
    query(3'd0, 8'hFF, 3'd7, "mask_full");

    // Asynchronous reset with a response on the outputs and a query queued.
    update(3'd0, 3'd7);
    vic_req = 1'b1; vic_index = 3'd0;
    step();
    check("pre_rst_way", vic_way, 3);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", vic_valid, 0);
    check("async_rst_way",   vic_way,   0);
    step();
    check("rst_held_valid", vic_valid, 0);
    vic_req = 1'b0;

    // Inputs present when reset releases act at that edge.
    upd_valid = 1'b1; upd_index = 3'd1; upd_way = 3'd7;
    vic_req   = 1'b1; vic_index = 3'd1;
    @(negedge clk);
    rst = 1'b1;
    step();
    upd_valid = 1'b0; vic_req = 1'b0;
    check("release_valid", vic_valid, 1);
    check("release_way",   vic_way,   3);
    query(3'd0, 8'hFF, 3'd7, "post_rst_set0");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
